// File: rtl/ttl_gfx_shift_seq.sv
// Sequencer feeding a pair of ttl_74194 shifters: fetches one GFX byte per
// 4-pixel group, applies horizontal flip and issues hold/shift/load modes.
module ttl_gfx_shift_seq #(
  parameter int         DELAY_RISE = 12,
  parameter int         DELAY_FALL = 15,
  parameter logic [3:0] BLANK_NIB  = 4'b0000
) (
  input  logic       CP,
  input  logic       CR_n,
  input  logic       PIX_CE,
  input  logic       ENABLE,
  input  logic       HFLIP,
  input  logic       ROM_ACK,
  input  logic [7:0] ROM_D,
  output logic       ROM_REQ,
  output logic       S1,
  output logic       S0,
  output logic [3:0] P0D,
  output logic [3:0] P1D,
  output logic       UNDERRUN
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_WAITLD = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  logic [1:0] state_reg;
  logic [1:0] ph_reg;
  logic [7:0] byte_reg;
  logic       byte_valid_reg;
  logic [3:0] rev_p0;
  logic [3:0] rev_p1;
  logic [3:0] load_p0;
  logic [3:0] load_p1;
  logic       ack_take;

  // Output delays only matter to timing-annotated simulation models.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_neg_delay
  end

  // P0D[3] reaches Q0 first, so flipping means reversing the nibble.
  for (genvar gi = 0; gi < 4; gi++) begin : g_flip
    assign rev_p0[gi] = byte_reg[3 - gi];
    assign rev_p1[gi] = byte_reg[7 - gi];
  end

  assign load_p0  = HFLIP ? rev_p0 : byte_reg[3:0];
  assign load_p1  = HFLIP ? rev_p1 : byte_reg[7:4];
  assign ack_take = ROM_ACK && ROM_REQ;

  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      state_reg      <= ST_IDLE;
      ph_reg         <= 2'd0;
      byte_reg       <= 8'h00;
      byte_valid_reg <= 1'b0;
      ROM_REQ        <= 1'b0;
      S1             <= 1'b0;
      S0             <= 1'b0;
      P0D            <= 4'h0;
      P1D            <= 4'h0;
      UNDERRUN       <= 1'b0;
    end else if (!ENABLE) begin
      state_reg      <= ST_IDLE;
      ph_reg         <= 2'd0;
      byte_valid_reg <= 1'b0;
      ROM_REQ        <= 1'b0;
      S1             <= 1'b0;
      S0             <= 1'b0;
    end else begin
      S1 <= 1'b0;
      S0 <= 1'b0;
      if (ack_take) begin
        byte_reg       <= ROM_D;
        byte_valid_reg <= 1'b1;
        ROM_REQ        <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_PRIME;
          ROM_REQ   <= 1'b1;
        end
        ST_PRIME: begin
          if (ack_take) state_reg <= ST_WAITLD;
        end
        ST_WAITLD: begin
          if (PIX_CE) begin
            S1             <= 1'b1;
            S0             <= 1'b1;
            P0D            <= load_p0;
            P1D            <= load_p1;
            byte_valid_reg <= 1'b0;
            ph_reg         <= 2'd0;
            state_reg      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (PIX_CE) begin
            if (ph_reg != 2'd3) begin
              S1     <= 1'b1;
              ph_reg <= ph_reg + 2'd1;
              if (ph_reg == 2'd1 && !ROM_REQ && !byte_valid_reg) ROM_REQ <= 1'b1;
            end else begin
              S1     <= 1'b1;
              S0     <= 1'b1;
              ph_reg <= 2'd0;
              if (byte_valid_reg) begin
                P0D            <= load_p0;
                P1D            <= load_p1;
                byte_valid_reg <= 1'b0;
              end else begin
                // Underrun cancels the fetch; a same-edge ack is discarded.
                P0D            <= BLANK_NIB;
                P1D            <= BLANK_NIB;
                UNDERRUN       <= 1'b1;
                ROM_REQ        <= 1'b0;
                byte_valid_reg <= 1'b0;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_gfx_shift_seq.sv
// Randomized bench for ttl_gfx_shift_seq: a pixel-stream reference model plus a
// behavioural 74194 pair checks modes, parallel data, handshake and Q0 pixels.
module tb_ttl_gfx_shift_seq;
  logic       CP = 1'b0;
  logic       CR_n = 1'b0;
  logic       PIX_CE = 1'b0;
  logic       ENABLE = 1'b0;
  logic       HFLIP = 1'b0;
  logic       ROM_ACK = 1'b0;
  logic [7:0] ROM_D = 8'h00;
  logic       ROM_REQ, S1, S0, UNDERRUN;
  logic [3:0] P0D, P1D;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CP = ~CP;

  ttl_gfx_shift_seq dut (
    .CP(CP), .CR_n(CR_n), .PIX_CE(PIX_CE), .ENABLE(ENABLE), .HFLIP(HFLIP),
    .ROM_ACK(ROM_ACK), .ROM_D(ROM_D), .ROM_REQ(ROM_REQ), .S1(S1), .S0(S0),
    .P0D(P0D), .P1D(P1D), .UNDERRUN(UNDERRUN)
  );

  // Downstream 74194 pair, bit 0 is Q0 (QA), fed from D0 = P?D[3].
  logic [3:0] q0, q1;
  logic       sh_act;
  always @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      q0 <= 4'h0; q1 <= 4'h0; sh_act <= 1'b0;
    end else begin
      sh_act <= S1 | S0;
      case ({S1, S0})
        2'b11: begin
          q0 <= {P0D[0], P0D[1], P0D[2], P0D[3]};
          q1 <= {P1D[0], P1D[1], P1D[2], P1D[3]};
        end
        2'b10: begin
          q0 <= {1'b0, q0[3:1]};
          q1 <= {1'b0, q1[3:1]};
        end
        default: ;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: line progress as a pixel count plus a byte queue.
  logic [3:0] blank_nib = 4'h0;
  bit         m_started, m_loaded;
  int         m_pix;
  logic [7:0] m_fifo[$];
  logic       e_req, e_und;
  logic [1:0] e_s;
  logic [3:0] e_p0, e_p1;
  logic [1:0] pixq[$];
  logic [1:0] pend_pix[4];
  bit         pend_valid;
  bit         resp_pend;
  int         resp_cnt;

  task automatic model_reset();
    m_started = 0; m_loaded = 0; m_pix = 0; m_fifo.delete();
    e_req = 0; e_und = 0; e_s = 0; e_p0 = 0; e_p1 = 0;
    pixq.delete(); pend_valid = 0; resp_pend = 0; resp_cnt = 0;
  endtask

  // Pixel order first, then P?D follows from "first pixel sits on D0".
  task automatic do_load(input logic [7:0] b, input bit hf, input bit blank);
    logic a, c;
    e_s = 2'b11; e_p0 = 4'h0; e_p1 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      a = blank ? blank_nib[3 - i] : (hf ? b[i]     : b[3 - i]);
      c = blank ? blank_nib[3 - i] : (hf ? b[4 + i] : b[7 - i]);
      pend_pix[i] = {c, a};
      e_p0[3 - i] = a;
      e_p1[3 - i] = c;
    end
    pend_valid = 1;
  endtask

  task automatic model_step(input bit en, input bit ce, input bit hf, input bit ack,
                            input logic [7:0] d);
    bit take;
    int ph;
    e_s = 2'b00;
    if (!en) begin
      m_started = 0; m_loaded = 0; m_pix = 0; m_fifo.delete(); e_req = 0;
    end else if (!m_started) begin
      m_started = 1; e_req = 1;
    end else begin
      take = ack && e_req;
      ph = m_pix % 4;
      if (ce && !m_loaded) begin
        if (m_fifo.size() > 0) begin
          do_load(m_fifo.pop_front(), hf, 0);
          m_loaded = 1; m_pix = 0;
        end
      end else if (ce) begin
        if (ph == 3) begin
          if (m_fifo.size() > 0) do_load(m_fifo.pop_front(), hf, 0);
          else begin
            do_load(8'h00, hf, 1);
            e_und = 1; e_req = 0; take = 0;
          end
        end else begin
          e_s = 2'b10;
          if (ph == 1 && !e_req && m_fifo.size() == 0) e_req = 1;
        end
        m_pix++;
      end
      if (take) begin
        m_fifo.push_back(d);
        e_req = 0;
      end
    end
  endtask

  task automatic async_reset();
    @(negedge CP);
    #2 CR_n = 1'b0;
    #1;
    check_val("rst_req", ROM_REQ, 0);
    check_val("rst_mode", {S1, S0}, 0);
    check_val("rst_p0d", P0D, 0);
    check_val("rst_p1d", P1D, 0);
    check_val("rst_underrun", UNDERRUN, 0);
    ENABLE = 0; PIX_CE = 0; ROM_ACK = 0; HFLIP = 0;
    model_reset();
    repeat (2) @(negedge CP);
    CR_n = 1'b1;
  endtask

  // Scenarios: normal A5, flip 1E, every-other CE, underrun/late ack, random with disables.
  int sc_ce[5]    = '{0, 0, 1, 0, 2};
  int sc_hf[5]    = '{0, 1, 2, 2, 2};
  int sc_d[5]     = '{'hA5, 'h1E, -1, -1, -1};
  int sc_lo[5]    = '{2, 2, 0, 3, 0};
  int sc_hi[5]    = '{2, 2, 4, 9, 7};
  int sc_spur[5]  = '{0, 0, 0, 60, 40};
  int sc_dis[5]   = '{0, 0, 0, 0, 25};

  task automatic run_scenario(input int s, input int cycles);
    bit en, ce, hf, ack;
    logic [7:0] d;
    logic [1:0] px;
    int lat;
    async_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge CP);
      if (sh_act) begin
        check_val("pix_avail", pixq.size() != 0, 1);
        if (pixq.size() != 0) begin
          px = pixq.pop_front();
          check_val("pix_q0", {q1[0], q0[0]}, px);
        end
      end
      if (pend_valid) begin
        pixq.delete();
        for (int i = 0; i < 4; i++) pixq.push_back(pend_pix[i]);
        pend_valid = 0;
      end
      check_val("mode", {S1, S0}, e_s);
      check_val("rom_req", ROM_REQ, e_req);
      check_val("p0d", P0D, e_p0);
      check_val("p1d", P1D, e_p1);
      check_val("underrun", UNDERRUN, e_und);

      if (ENABLE) en = ($urandom_range(999, 0) >= sc_dis[s]);
      else en = (cyc < 2) || ($urandom_range(99, 0) < 30);
      case (sc_ce[s])
        0: ce = 1;
        1: ce = cyc[0];
        default: ce = ($urandom_range(99, 0) < 60);
      endcase
      hf = (sc_hf[s] == 2) ? 1'($urandom_range(1, 0)) : (sc_hf[s] == 1);
      ack = 0;
      d = 8'($urandom());
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          ack = 1; resp_pend = 0;
          d = ROM_REQ ? ((sc_d[s] >= 0) ? 8'(sc_d[s]) : d) : 8'hFF;
        end else resp_cnt--;
      end else if (ROM_REQ) begin
        lat = $urandom_range(sc_hi[s], sc_lo[s]);
        if (lat == 0) begin
          ack = 1;
          if (sc_d[s] >= 0) d = 8'(sc_d[s]);
        end else begin
          resp_pend = 1; resp_cnt = lat - 1;
        end
      end
      if (!ack && $urandom_range(999, 0) < sc_spur[s]) begin
        ack = 1; d = 8'hFF;
      end
      ENABLE = en; PIX_CE = ce; HFLIP = hf; ROM_ACK = ack; ROM_D = d;
      model_step(en, ce, hf, ack, d);
    end
  endtask

  initial begin
    model_reset();
    for (int s = 0; s < 5; s++) run_scenario(s, 300);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
